// File: rtl/lbp_stream_engine_if.sv
// Pixel-source and result-sink signals of the LBP stream engine, bundled for
// the engine (master) and its surrounding memories/sink (slave).
interface lbp_stream_engine_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
) ();
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic [PIX_W-1:0]  thresh;
  logic              lbp_valid;
  logic              lbp_ready;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;

  // Result handshake: a result transfers on a cycle with lbp_valid & lbp_ready;
  // while lbp_valid is high and lbp_ready low, lbp_valid/lbp_addr/lbp_data hold.
  modport master (
    input  gray_ready, gray_data, thresh, lbp_ready,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, gray_data, thresh, lbp_ready,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_stream_engine.sv
// Raster-scan LBP engine: reads each pixel once, keeps two line buffers and a
// 3x3 window, emits one code per interior pixel and optionally zero-fills the border.
module lbp_stream_engine #(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 14,
  parameter int ZERO_BORDER = 0
) (
  input  logic                clk,
  input  logic                reset,
  lbp_stream_engine_if.master bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_CAP    = 3'd2,
    S_EMIT   = 3'd3,
    S_BORDER = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int C_W = $clog2(IMG_W);
  localparam int R_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] CTR_OFS  = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] B_SKIP   = ADDR_W'(IMG_W - 1);
  localparam logic [C_W-1:0]    C_MAX    = C_W'(IMG_W - 1);
  localparam logic [R_W-1:0]    R_MAX    = R_W'(IMG_H - 1);

  state_t state, state_n;

  logic [ADDR_W-1:0] idx;
  logic [R_W-1:0]    r;
  logic [C_W-1:0]    c;
  logic [PIX_W-1:0]  thresh_q;
  logic [PIX_W-1:0]  win [3][3];
  logic [PIX_W-1:0]  lb1 [IMG_W];
  logic [PIX_W-1:0]  lb2 [IMG_W];
  logic [R_W-1:0]    br;
  logic [C_W-1:0]    bc;
  logic [ADDR_W-1:0] b_addr;

  logic start, cap, adv, b_init, b_adv;
  logic last_pix, win_full, b_last, b_mid;
  logic [PIX_W:0]   cmp_ref;
  logic [PIX_W-1:0] nb [8];
  logic [7:0]       code;

  assign last_pix  = (idx == LAST_IDX);
  assign win_full  = (r >= R_W'(2)) && (c >= C_W'(2));
  assign b_last    = (br == R_MAX) && (bc == C_MAX);
  assign b_mid     = (br != '0) && (br != R_MAX);
  assign dbg_state = state;

  // Comparison in PIX_W+1 bits so centre+thresh never wraps to a small value.
  always_comb begin
    cmp_ref = {1'b0, win[1][1]} + {1'b0, thresh_q};
    nb[0] = win[0][0];
    nb[1] = win[0][1];
    nb[2] = win[0][2];
    nb[3] = win[1][0];
    nb[4] = win[1][2];
    nb[5] = win[2][0];
    nb[6] = win[2][1];
    nb[7] = win[2][2];
    code = '0;
    for (int k = 0; k < 8; k++) code[k] = ({1'b0, nb[k]} >= cmp_ref);
  end

  always_comb begin
    state_n       = state;
    bus.gray_req  = 1'b0;
    bus.gray_addr = '0;
    bus.lbp_valid = 1'b0;
    bus.lbp_addr  = '0;
    bus.lbp_data  = '0;
    bus.finish    = 1'b0;
    start         = 1'b0;
    cap           = 1'b0;
    adv           = 1'b0;
    b_init        = 1'b0;
    b_adv         = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.gray_ready) begin
          start   = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        bus.gray_req  = 1'b1;
        bus.gray_addr = idx;
        state_n       = S_CAP;
      end
      S_CAP: begin
        cap = 1'b1;
        if (win_full) begin
          state_n = S_EMIT;
        end else if (!last_pix) begin
          adv     = 1'b1;
          state_n = S_REQ;
        end else begin
          b_init = 1'b1;
          if (ZERO_BORDER != 0) state_n = S_BORDER;
          else                  state_n = S_DONE;
        end
      end
      S_EMIT: begin
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = idx - CTR_OFS;
        bus.lbp_data  = code;
        if (bus.lbp_ready) begin
          if (!last_pix) begin
            adv     = 1'b1;
            state_n = S_REQ;
          end else begin
            b_init = 1'b1;
            if (ZERO_BORDER != 0) state_n = S_BORDER;
            else                  state_n = S_DONE;
          end
        end
      end
      S_BORDER: begin
        bus.lbp_valid = 1'b1;
        bus.lbp_addr  = b_addr;
        if (bus.lbp_ready) begin
          if (b_last) state_n = S_DONE;
          else        b_adv   = 1'b1;
        end
      end
      S_DONE: begin
        bus.finish = 1'b1;
        if (bus.gray_ready) begin
          start   = 1'b1;
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      r        <= '0;
      c        <= '0;
      thresh_q <= '0;
      br       <= '0;
      bc       <= '0;
      b_addr   <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (start) begin
        thresh_q <= bus.thresh;
        idx      <= '0;
        r        <= '0;
        c        <= '0;
      end
      // New right column: rows r-2 and r-1 from the line buffers, row r from memory.
      if (cap) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb2[c];
        win[1][2] <= lb1[c];
        win[2][2] <= bus.gray_data;
        lb2[c]    <= lb1[c];
        lb1[c]    <= bus.gray_data;
      end
      if (adv) begin
        idx <= idx + ADDR_W'(1);
        if (c == C_MAX) begin
          c <= '0;
          r <= r + R_W'(1);
        end else begin
          c <= c + C_W'(1);
        end
      end
      if (b_init) begin
        br     <= '0;
        bc     <= '0;
        b_addr <= '0;
      end
      // Border walk: full top/bottom rows; middle rows visit only column 0 then IMG_W-1.
      if (b_adv) begin
        b_addr <= b_addr + ((b_mid && bc == '0) ? B_SKIP : ADDR_W'(1));
        if (!b_mid) begin
          if (bc == C_MAX) begin
            br <= br + R_W'(1);
            bc <= '0;
          end else begin
            bc <= bc + C_W'(1);
          end
        end else if (bc == '0) begin
          bc <= C_MAX;
        end else begin
          br <= br + R_W'(1);
          bc <= '0;
        end
      end
    end
  end

endmodule
